// File: rtl/lfsr_rng_server_pkg.sv
// Shared constants, types and the reference LFSR step for the random-number server.
// The Galois form shifts right and folds TAPS in whenever the bit shifted out is 1.
package lfsr_pkg;

  localparam int LFSR_W = 5;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 5'b10100;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 5'b00001;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } fsm_state_t;

  function automatic lfsr_t lfsr_step(lfsr_t s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

endpackage

// File: rtl/lfsr_rng_server_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr, wrapping around.
// The pointer moves one past the winner only when a grant is actually issued.
module rr_arbiter
  import lfsr_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    en,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IW+1)'(k);
      if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
      cand = sum[IW-1:0];
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    if (en && found) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_rng_server.sv
// One LFSR shared by NREQ requesters; each grant hands out the current state and steps it.
// A held response blocks new grants until resp_rdy; seed loads block grants for a cycle.
module lfsr_rng_server
  import lfsr_pkg::*;
#(
  parameter int                NREQ  = 4,
  parameter int                WIDTH = LFSR_W,
  parameter logic [WIDTH-1:0]  TAPS  = LFSR_TAPS,
  parameter logic [WIDTH-1:0]  SEED  = LFSR_SEED
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_val,
  output logic [NREQ-1:0]         req_rdy,
  output logic                    resp_val,
  input  logic                    resp_rdy,
  output logic [$clog2(NREQ)-1:0] resp_id,
  output logic [WIDTH-1:0]        resp_data,
  input  logic                    cfg_seed_val,
  input  logic [WIDTH-1:0]        cfg_seed,
  output logic                    cfg_err,
  output logic [15:0]             stat_count
);

  localparam int IW = $clog2(NREQ);

  function automatic logic [WIDTH-1:0] step(logic [WIDTH-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  fsm_state_t       state, state_nxt;
  logic [WIDTH-1:0] lfsr;
  logic [NREQ-1:0]  grant;
  logic [IW-1:0]    grant_idx;
  logic             grant_en;
  logic             any_grant;
  logic [IW-1:0]    id_p1;
  logic [WIDTH-1:0] data_p1;

  // reset gates grant_en so req_rdy stays low while reset is held
  assign grant_en  = reset && ((state == IDLE) || resp_rdy) && !cfg_seed_val;
  assign any_grant = |grant;
  assign req_rdy   = grant;
  assign resp_id   = id_p1;
  assign resp_data = data_p1;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req_val),
    .en        (grant_en),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    state_nxt = state;
    resp_val  = (state == RESP);
    case (state)
      IDLE:    if (any_grant) state_nxt = RESP;
      RESP:    if (resp_rdy) state_nxt = any_grant ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // all-zero seed would lock the LFSR, so it is replaced by SEED and flagged
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr    <= SEED;
      cfg_err <= 1'b0;
    end else if (cfg_seed_val) begin
      if (cfg_seed == '0) begin
        lfsr    <= SEED;
        cfg_err <= 1'b1;
      end else begin
        lfsr <= cfg_seed;
      end
    end else if (any_grant) begin
      lfsr <= step(lfsr);
    end
  end

  // stage p1: response registers, loaded on grant and held until drained
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_p1   <= '0;
      data_p1 <= '0;
    end else if (any_grant) begin
      id_p1   <= grant_idx;
      data_p1 <= lfsr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   stat_count <= '0;
    else if (resp_val && resp_rdy) stat_count <= stat_count + 16'd1;
  end

endmodule
